// File: rtl/fft_control.sv
// rtl/fft_control.sv - address/twiddle sequencer for a 64-point in-place radix-2 FFT
// Walks 6 stages x 32 butterflies; the twiddle address leads the RAM addresses by one cycle.
module fft_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [5:0] address_a,
  output logic [5:0] address_b,
  output logic       write,
  output logic [4:0] twiddle_address,
  output logic [2:0] stage,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [2:0] s;
  logic [4:0] i;
  logic       last;
  logic [2:0] next_s;
  logic [4:0] next_i;

  assign last   = (s == 3'd5) && (i == 5'd31);
  assign next_i = i + 5'd1;
  assign next_s = (i == 5'd31) ? s + 3'd1 : s;

  function automatic logic [5:0] rotl6(input logic [5:0] x, input logic [2:0] k);
    logic [11:0] d;
    d = {x, x} << k;
    return d[11:6];
  endfunction

  // Early stages share few twiddles: only the top s bits of i select the factor.
  function automatic logic [4:0] tw(input logic [2:0] ss, input logic [4:0] ii);
    return ii & ~(5'b11111 >> ss);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= 3'd0;
      i     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= PRIME;
            s     <= 3'd0;
            i     <= 5'd0;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          if (last) begin
            state <= DONE;
            s     <= 3'd0;
            i     <= 5'd0;
          end else begin
            i <= next_i;
            s <= next_s;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock edge.
  always_comb begin
    address_a       = 6'd0;
    address_b       = 6'd0;
    write           = 1'b0;
    twiddle_address = 5'd0;
    stage           = 3'd0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      PRIME: begin
        busy            = 1'b1;
        twiddle_address = tw(3'd0, 5'd0);
      end
      RUN: begin
        address_a       = rotl6({i, 1'b0}, s);
        address_b       = rotl6({i, 1'b1}, s);
        write           = 1'b1;
        stage           = s;
        busy            = 1'b1;
        twiddle_address = last ? 5'd0 : tw(next_s, next_i);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_control.sv
// tb/tb_fft_control.sv - self-checking bench for fft_control
// Reference: a transform is a 194-cycle script indexed by cycles since start was accepted.
module tb_fft_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] address_a, address_b;
  logic       write;
  logic [4:0] twiddle_address;
  logic [2:0] stage;
  logic       busy, done;

  fft_control dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .address_a(address_a), .address_b(address_b), .write(write),
    .twiddle_address(twiddle_address), .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic       w;
    logic [4:0] tw;
    logic [2:0] st;
    logic       bz;
    logic       dn;
  } outs_t;

  typedef struct {
    int s; int i; int a; int b; int tw;
  } spot_t;

  int tests = 0;
  int fails = 0;
  int cnt = 0;
  int cyc = 0;
  spot_t spots[6];

  int busy_n, write_n, done_n, done_at, run_j;
  logic [63:0] cov[6];
  int dup_n;

  // 0 = idle, 1 = prime, 2..193 = butterfly cnt-2, 194 = done
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else if (cnt == 0) begin
      if (start) cnt <= 1;
    end else if (cnt == 194) cnt <= 0;
    else cnt <= cnt + 1;
  end

  function automatic int rot6(int x, int s);
    return ((x << s) | (x >> (6 - s))) & 63;
  endfunction

  function automatic int twf(int k);
    int s, i;
    s = k / 32;
    i = k % 32;
    return (i >> (5 - s)) << (5 - s);
  endfunction

  function automatic outs_t model_out(int c);
    outs_t o;
    int k;
    o = '0;
    if (c == 1) o.bz = 1'b1;
    else if (c >= 2 && c <= 193) begin
      k = c - 2;
      o.a  = 6'(rot6(2 * (k % 32), k / 32));
      o.b  = 6'(rot6(2 * (k % 32) + 1, k / 32));
      o.w  = 1'b1;
      o.bz = 1'b1;
      o.st = 3'(k / 32);
      o.tw = (k < 191) ? 5'(twf(k + 1)) : 5'd0;
    end else if (c == 194) o.dn = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    outs_t act;
    @(negedge clk);
    cyc++;
    run_j++;
    act = {address_a, address_b, write, twiddle_address, stage, busy, done};
    check($sformatf("outputs@cnt%0d", cnt), 32'(act), 32'(model_out(cnt)));
    foreach (spots[n]) begin
      if (cnt == 2 + 32 * spots[n].s + spots[n].i) begin
        check($sformatf("addr_a(%0d,%0d)", spots[n].s, spots[n].i), 32'(address_a), spots[n].a);
        check($sformatf("addr_b(%0d,%0d)", spots[n].s, spots[n].i), 32'(address_b), spots[n].b);
      end
      if (cnt == 1 + 32 * spots[n].s + spots[n].i)
        check($sformatf("tw_early(%0d,%0d)", spots[n].s, spots[n].i), 32'(twiddle_address), spots[n].tw);
    end
    if (busy) busy_n++;
    if (write) begin
      write_n++;
      if (cov[stage][address_a] || cov[stage][address_b] || address_a == address_b) dup_n++;
      cov[stage][address_a] = 1'b1;
      cov[stage][address_b] = 1'b1;
    end
    if (done) begin
      done_n++;
      done_at = run_j;
    end
  endtask

  task automatic clear_stats();
    busy_n = 0; write_n = 0; done_n = 0; done_at = -1; run_j = 0; dup_n = 0;
    foreach (cov[n]) cov[n] = '0;
  endtask

  task automatic check_lengths(input string tag);
    check({tag, "_busy_cycles"}, busy_n, 193);
    check({tag, "_write_cycles"}, write_n, 192);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_cycle"}, done_at, 194);
  endtask

  int last_done;

  initial begin
    spots[0] = '{0, 0, 0, 1, 0};
    spots[1] = '{1, 1, 4, 6, 0};
    spots[2] = '{2, 3, 24, 28, 0};
    spots[3] = '{3, 5, 17, 25, 4};
    spots[4] = '{5, 31, 31, 63, 31};
    spots[5] = '{1, 0, 0, 2, 0};
    clear_stats();

    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();

    // plain transform with coverage of every address per stage
    start = 1'b1;
    clear_stats();
    tick();
    start = 1'b0;
    repeat (199) tick();
    check_lengths("full");
    for (int s = 0; s < 6; s++) check($sformatf("cover_stage%0d", s), 32'(&cov[s]), 32'd1);
    check("cover_duplicates", dup_n, 0);

    // start re-pulsed in RUN cycle 50 is ignored
    start = 1'b1;
    clear_stats();
    tick();
    start = 1'b0;
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (148) tick();
    check_lengths("repulse");

    // reset in RUN cycle 100 drops outputs before any clock edge
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_write", 32'(write), 0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1;
    clear_stats();
    tick();
    start = 1'b0;
    repeat (199) tick();
    check_lengths("restart");

    // random start pulses and occasional resets
    for (int n = 0; n < 800; n++) begin
      start = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    start = 1'b0;
    repeat (200) tick();

    // held start runs back-to-back with a 195-cycle period
    start = 1'b1;
    last_done = -1;
    clear_stats();
    for (int n = 0; n < 600; n++) begin
      tick();
      if (done) begin
        if (last_done >= 0) check("b2b_period", run_j - last_done, 195);
        last_done = run_j;
      end
    end
    start = 1'b0;
    check("b2b_transforms", done_n, 3);
    repeat (200) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
